// File: rtl/aes_ctrl_fsm_pkg.sv
// aes_ctrl_package: shared types and constants for the AES job sequencer
package aes_ctrl_package;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ABORT
    } aes_ctrl_state_e;

    typedef enum logic [1:0] {
        ERR_OK,
        ERR_ZLEN,
        ERR_ABORT,
        ERR_WDOG
    } aes_ctrl_err_e;

    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef struct packed {
        logic clear;
        logic src_start;
        logic sink_start;
        logic enable;
        logic busy;
        logic evt;
    } aes_ctrl_ctrl_t;

    typedef struct packed {
        logic src_done;
        logic sink_done;
    } aes_ctrl_flags_t;

endpackage

// File: rtl/aes_ctrl_fsm_wdog.sv
// aes_ctrl_wdog: inactivity watchdog, expires when the count reaches all-ones
module aes_ctrl_wdog #(
    parameter int unsigned W = 20
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic kick_i,
    input  logic en_i,
    output logic expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // restart on load or activity, otherwise count while enabled
    always_comb cnt_d = (load_i || kick_i) ? '0 : en_i ? cnt_q + W'(1) : cnt_q;

    assign expire_o = en_i && (cnt_d == '1);

    // counter register
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/aes_ctrl_fsm.sv
// aes_ctrl_fsm: job sequencer launching streamer and engine, counting blocks
module aes_ctrl_fsm
    import aes_ctrl_package::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WDOG_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [CNT_W-1:0]  n_blocks_i,
    output logic              src_start_o,
    output logic              sink_start_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [ADDR_W-1:0] dst_addr_o,
    output logic [CNT_W+1:0]  len_words_o,
    input  logic              src_done_i,
    input  logic              sink_done_i,
    input  logic              blk_done_i,
    output logic              clear_o,
    output logic              enable_o,
    output logic              busy_o,
    output logic              evt_o,
    output logic [1:0]        err_o,
    output logic [CNT_W-1:0]  blk_cnt_o
);
    aes_ctrl_state_e   state_q, state_d;
    aes_ctrl_err_e     err_q, err_d;
    aes_ctrl_flags_t   flags_q, flags_d;
    aes_ctrl_ctrl_t    ctrl;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [CNT_W-1:0]  n_q, n_d, cnt_q, cnt_d;
    logic              wd_load, wd_kick, wd_en, wd_expire;

    assign wd_load = state_q == S_LAUNCH;
    assign wd_en   = state_q == S_RUN;
    assign wd_kick = blk_done_i || sink_done_i;

    aes_ctrl_wdog #(.W(WDOG_W)) u_wdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (wd_load),
        .kick_i  (wd_kick),
        .en_i    (wd_en),
        .expire_o(wd_expire)
    );

    // next-state, job bookkeeping and control pulses
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        flags_d      = flags_q;
        src_d        = src_q;
        dst_d        = dst_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        ctrl         = '0;
        ctrl.enable  = 1'b1;
        case (state_q)
            S_IDLE: if (start_i) begin
                src_d   = src_addr_i;
                dst_d   = dst_addr_i;
                n_d     = n_blocks_i;
                cnt_d   = '0;
                err_d   = (n_blocks_i == '0) ? ERR_ZLEN : ERR_OK;
                state_d = (n_blocks_i == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                ctrl.clear = 1'b1;
                ctrl.busy  = 1'b1;
                flags_d    = '0;
                state_d    = abort_i ? S_ABORT : S_LAUNCH;
                err_d      = abort_i ? ERR_ABORT : err_q;
            end
            S_LAUNCH: begin
                ctrl.src_start  = 1'b1;
                ctrl.sink_start = 1'b1;
                ctrl.busy       = 1'b1;
                state_d         = abort_i ? S_ABORT : S_RUN;
                err_d           = abort_i ? ERR_ABORT : err_q;
            end
            S_RUN: begin
                ctrl.busy         = 1'b1;
                cnt_d             = (blk_done_i && cnt_q != n_q) ? cnt_q + CNT_W'(1) : cnt_q;
                flags_d.src_done  = flags_q.src_done || src_done_i;
                flags_d.sink_done = flags_q.sink_done || sink_done_i;
                if (abort_i) begin
                    state_d = S_ABORT;
                    err_d   = ERR_ABORT;
                end else if (flags_d.sink_done && cnt_d == n_q) begin
                    state_d = S_DONE;
                end else if (wd_expire) begin
                    state_d = S_ABORT;
                    err_d   = ERR_WDOG;
                end
            end
            S_ABORT: begin
                ctrl.clear = 1'b1;
                ctrl.busy  = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                ctrl.evt = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state, latched job and counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            err_q   <= ERR_OK;
            flags_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
        end
    end

    assign src_start_o  = ctrl.src_start;
    assign sink_start_o = ctrl.sink_start;
    assign clear_o      = ctrl.clear;
    assign enable_o     = ctrl.enable;
    assign busy_o       = ctrl.busy;
    assign evt_o        = ctrl.evt;
    assign src_addr_o   = src_q;
    assign dst_addr_o   = dst_q;
    assign len_words_o  = {n_q, {$clog2(WORDS_PER_BLOCK){1'b0}}};
    assign err_o        = err_q;
    assign blk_cnt_o    = cnt_q;
endmodule

// File: tb/tb_aes_ctrl_fsm.sv
// tb_aes_ctrl_fsm: directed self-checking bench for the AES job sequencer
module tb_aes_ctrl_fsm;
    logic        clk_i = 1'b0;
    logic        rst_i, start_i, abort_i, src_done_i, sink_done_i, blk_done_i;
    logic [31:0] src_addr_i, dst_addr_i, src_addr_o, dst_addr_o;
    logic [15:0] n_blocks_i, blk_cnt_o;
    logic [17:0] len_words_o;
    logic        src_start_o, sink_start_o, clear_o, enable_o, busy_o, evt_o;
    logic [1:0]  err_o;
    int          checks = 0;
    int          errors = 0;

    aes_ctrl_fsm #(.ADDR_W(32), .CNT_W(16), .WDOG_W(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .n_blocks_i  (n_blocks_i),
        .src_start_o (src_start_o),
        .sink_start_o(sink_start_o),
        .src_addr_o  (src_addr_o),
        .dst_addr_o  (dst_addr_o),
        .len_words_o (len_words_o),
        .src_done_i  (src_done_i),
        .sink_done_i (sink_done_i),
        .blk_done_i  (blk_done_i),
        .clear_o     (clear_o),
        .enable_o    (enable_o),
        .busy_o      (busy_o),
        .evt_o       (evt_o),
        .err_o       (err_o),
        .blk_cnt_o   (blk_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic launch(input logic [15:0] n, input logic [31:0] src, input logic [31:0] dst);
        start_i    = 1'b1;
        n_blocks_i = n;
        src_addr_i = src;
        dst_addr_i = dst;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        src_done_i = 1'b0; sink_done_i = 1'b0; blk_done_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; n_blocks_i = '0;
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_enable", enable_o, 1);
        check("rst_err", err_o, 0);
        check("rst_blk", blk_cnt_o, 0);
        check("rst_len", len_words_o, 0);
        check("rst_pulses", {src_start_o, sink_start_o, clear_o, evt_o}, 0);
        rst_i = 1'b0;
        tick();

        // T1: normal three-block job with an extra block pulse and src_done alone
        launch(16'd3, 32'h1000, 32'h2000);
        check("t1_clear", clear_o, 1);
        check("t1_clear_busy", busy_o, 1);
        check("t1_clear_nosrc", src_start_o, 0);
        tick();
        check("t1_launch", {src_start_o, sink_start_o, clear_o}, 3'b110);
        check("t1_len", len_words_o, 12);
        check("t1_src", src_addr_o, 32'h1000);
        check("t1_dst", dst_addr_o, 32'h2000);
        tick();
        check("t1_run_nosrc", src_start_o, 0);
        blk_done_i = 1'b1;
        repeat (4) tick();
        blk_done_i = 1'b0;
        check("t1_blk_sat", blk_cnt_o, 3);
        check("t1_run_busy", busy_o, 1);
        src_done_i = 1'b1;
        tick();
        src_done_i = 1'b0;
        check("t1_srcdone_only", {busy_o, evt_o}, 2'b10);
        sink_done_i = 1'b1;
        tick();
        sink_done_i = 1'b0;
        check("t1_evt", evt_o, 1);
        check("t1_done_busy", busy_o, 0);
        check("t1_err", err_o, 0);
        check("t1_blk", blk_cnt_o, 3);
        tick();
        check("t1_evt_off", evt_o, 0);

        // T2: zero-length job
        launch(16'd0, 32'h5000, 32'h6000);
        check("t2_evt", evt_o, 1);
        check("t2_noclear", {clear_o, src_start_o, busy_o}, 0);
        check("t2_err", err_o, 1);
        tick();
        check("t2_evt_off", evt_o, 0);

        // T3: abort in RUN after one block
        launch(16'd2, 32'h1100, 32'h2200);
        tick(); tick();
        blk_done_i = 1'b1;
        tick();
        blk_done_i = 1'b0;
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t3_abort_clear", {clear_o, busy_o, evt_o}, 3'b110);
        tick();
        check("t3_evt", evt_o, 1);
        check("t3_err", err_o, 2);
        check("t3_blk", blk_cnt_o, 1);
        tick();

        // T4: watchdog expiry with no activity
        launch(16'd1, 32'h1000, 32'h2000);
        tick(); tick();
        repeat (14) tick();
        check("t4_still_run", {clear_o, busy_o}, 2'b01);
        tick();
        check("t4_abort_clear", clear_o, 1);
        tick();
        check("t4_evt", evt_o, 1);
        check("t4_err", err_o, 3);
        check("t4_blk", blk_cnt_o, 0);
        tick();

        // T5a: last block and sink done in the same cycle
        launch(16'd1, 32'h1000, 32'h2000);
        tick(); tick();
        blk_done_i = 1'b1; sink_done_i = 1'b1;
        tick();
        blk_done_i = 1'b0; sink_done_i = 1'b0;
        check("t5a_evt", evt_o, 1);
        check("t5a_err", err_o, 0);
        check("t5a_blk", blk_cnt_o, 1);
        tick();

        // T5b: same completion but abort wins
        launch(16'd1, 32'h1000, 32'h2000);
        tick(); tick();
        blk_done_i = 1'b1; sink_done_i = 1'b1; abort_i = 1'b1;
        tick();
        blk_done_i = 1'b0; sink_done_i = 1'b0; abort_i = 1'b0;
        check("t5b_abort", {clear_o, evt_o}, 2'b10);
        tick();
        check("t5b_evt", evt_o, 1);
        check("t5b_err", err_o, 2);
        tick();

        // T6: start while busy ignored, then reset mid-RUN
        launch(16'd2, 32'h3000, 32'h4000);
        tick(); tick();
        launch(16'd5, 32'h7000, 32'h8000);
        check("t6_len_kept", len_words_o, 8);
        check("t6_src_kept", src_addr_o, 32'h3000);
        check("t6_still_run", {busy_o, clear_o, src_start_o}, 3'b100);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("t6_rst", {busy_o, evt_o, clear_o}, 0);
        check("t6_rst_len", len_words_o, 0);
        tick();
        check("t6_no_evt", {evt_o, busy_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
